// File: rtl/scp_pc_sequencer.sv
// Program-counter sequencer: run/pause/single-step control, redirects,
// end-of-program detection, out-of-range trapping and a retired-instruction counter.
module scp_pc_sequencer #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             single_step,
  input  logic             step,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic [31:0]      end_pc,
  output logic [31:0]      pcounter,
  output logic             pc_valid,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned STATE_W = 3;
  localparam logic [PC_W-1:0] DEPTH = PC_W'(IMEM_DEPTH);

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_RUN   = 3'd1;
  localparam logic [STATE_W-1:0] S_PAUSE = 3'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd3;
  localparam logic [STATE_W-1:0] S_FAULT = 3'd4;

  logic [STATE_W-1:0] state, state_d;
  logic [PC_W-1:0]    pc_d, pc_next;
  logic [CNT_W-1:0]   cnt_d, cnt_sat;
  logic               pc_valid_d, busy_d, done_d, fault_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pcounter      <= '0;
      retired_count <= '0;
      pc_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_d;
      pcounter      <= pc_d;
      retired_count <= cnt_d;
      pc_valid      <= pc_valid_d;
      busy          <= busy_d;
      done          <= done_d;
      fault         <= fault_d;
    end
  end

  // Next state, next PC, next count; flags are decoded from the next state
  always_comb begin
    state_d = state;
    pc_d    = pcounter;
    cnt_d   = retired_count;
    pc_next = redirect_valid ? redirect_target : pcounter + PC_W'(1);
    cnt_sat = (&retired_count) ? retired_count : retired_count + CNT_W'(1);

    case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_sat;
        if (pcounter == end_pc) begin
          state_d = S_DONE;
        end else if (pc_next >= DEPTH) begin
          state_d = S_FAULT;
        end else begin
          pc_d = pc_next;
          if (stop || single_step) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start || step) state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase

    pc_valid_d = (state_d == S_RUN);
    busy_d     = (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d     = (state_d == S_DONE);
    fault_d    = (state_d == S_FAULT);
  end

endmodule

// File: tb/tb_scp_pc_sequencer.sv
// Scoreboard bench for scp_pc_sequencer: a behavioural program-execution model
// predicts every post-edge output; a negedge monitor compares against the DUT.
module tb_scp_pc_sequencer;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned CW    = 9;
  localparam longint CNT_MAX = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, stop = 1'b0, single_step = 1'b0, step = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_target = '0;
  logic [31:0]   end_pc = '0;
  logic [31:0]   pcounter;
  logic          pc_valid, busy, done, fault;
  logic [CW-1:0] retired_count;

  scp_pc_sequencer #(.IMEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .single_step(single_step), .step(step),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .end_pc(end_pc), .pcounter(pcounter), .pc_valid(pc_valid),
    .busy(busy), .done(done), .fault(fault), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE, M_FAULT} mode_t;
  typedef struct {
    longint pc;
    longint cnt;
    bit     valid, busy, done, fault;
  } exp_t;

  mode_t  m_mode = M_IDLE;
  longint m_pc   = 0;
  longint m_cnt  = 0;
  exp_t   sb_q[$];
  int     total = 0;
  int     bad   = 0;

  function automatic void check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Program-level model: one instruction retires per RUN edge
  task automatic model_edge();
    longint nxt;
    if (reset) begin
      m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE, M_FAULT:
          if (start) begin m_mode = M_RUN; m_pc = 0; m_cnt = 0; end
        M_RUN: begin
          if (m_cnt < CNT_MAX) m_cnt++;
          if (m_pc == longint'(end_pc)) m_mode = M_DONE;
          else begin
            nxt = redirect_valid ? longint'(redirect_target) : (m_pc + 1) % (longint'(1) << 32);
            if (nxt >= DEPTH) m_mode = M_FAULT;
            else begin
              m_pc = nxt;
              if (stop || single_step) m_mode = M_PAUSE;
            end
          end
        end
        M_PAUSE: if (start || step) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  // Advance one edge: model consumes the same inputs the DUT samples
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.pc = m_pc; e.cnt = m_cnt;
    e.valid = (m_mode == M_RUN);
    e.busy  = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    e.done  = (m_mode == M_DONE);
    e.fault = (m_mode == M_FAULT);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Monitor: compare the DUT's current outputs with the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("pcounter", longint'(pcounter), e.pc);
      check("retired_count", longint'(retired_count), e.cnt);
      check("pc_valid", longint'(pc_valid), longint'(e.valid));
      check("busy", longint'(busy), longint'(e.busy));
      check("done", longint'(done), longint'(e.done));
      check("fault", longint'(fault), longint'(e.fault));
    end
  end

  // Run with a redirect injected when the model PC reaches a given address
  task automatic run_redirect(longint at_pc, logic [31:0] tgt, int cycles);
    for (int i = 0; i < cycles; i++) begin
      redirect_valid  = (m_mode == M_RUN) && (m_pc == at_pc);
      redirect_target = tgt;
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_pc", longint'(pcounter), 0);
    check("reset_flags", longint'({pc_valid, busy, done, fault}), 0);

    // Linear run 0..33
    end_pc = 33;
    pulse_start();
    @(negedge clk);
    check("lin_first_pc", longint'(pcounter), 0);
    check("lin_first_valid", longint'(pc_valid), 1);
    repeat (34) tick();
    @(negedge clk);
    check("lin_done", longint'(done), 1);
    check("lin_count", longint'(retired_count), 34);
    check("lin_pc", longint'(pcounter), 33);

    // Redirect 3 -> 10, end at 12
    end_pc = 12;
    pulse_start();
    run_redirect(3, 32'd10, 10);
    @(negedge clk);
    check("redir_done", longint'(done), 1);
    check("redir_count", longint'(retired_count), 7);
    check("redir_pc", longint'(pcounter), 12);

    // Single step
    end_pc = 100; single_step = 1'b1;
    pulse_start();
    tick();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      @(negedge clk);
      check("ss_valid_after_step", longint'(pc_valid), 1);
      tick(); tick();
      @(negedge clk);
      check("ss_paused", longint'({pc_valid, busy}), 1);
    end
    check("ss_count", longint'(retired_count), 4);
    single_step = 1'b0;

    // Fault via redirect beyond memory
    pulse_start();
    run_redirect(5, 32'd256, 10);
    @(negedge clk);
    check("fault_flag", longint'(fault), 1);
    check("fault_pc", longint'(pcounter), 5);
    check("fault_count", longint'(retired_count), 6);
    step = 1'b1; stop = 1'b1; tick(); step = 1'b0; stop = 1'b0;

    // Fault by running off the end of memory
    end_pc = 300;
    pulse_start();
    repeat (260) tick();
    @(negedge clk);
    check("eom_fault", longint'(fault), 1);
    check("eom_pc", longint'(pcounter), 255);
    check("eom_count", longint'(retired_count), 256);

    // Stop at 4, resume with start
    end_pc = 100;
    pulse_start();
    for (int i = 0; i < 10 && m_pc != 4; i++) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("stop_pc", longint'(pcounter), 5);
    check("stop_busy_novalid", longint'({busy, pc_valid}), 2);
    pulse_start();
    @(negedge clk);
    check("resume_pc", longint'(pcounter), 5);
    check("resume_count", longint'(retired_count), 5);
    repeat (3) tick();

    // Reset mid-run at 7, then restart
    pulse_start();
    for (int i = 0; i < 12 && m_pc != 7; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    check("midreset_outputs", longint'({pc_valid, busy, done, fault}), 0);
    check("midreset_pc", longint'(pcounter), 0);
    pulse_start();
    repeat (3) tick();

    // Counter saturation: loop 200 -> 0 forever
    end_pc = 1000;
    pulse_start();
    run_redirect(200, 32'd0, 600);
    @(negedge clk);
    check("sat_count", longint'(retired_count), CNT_MAX);

    // Randomized run control
    for (int i = 0; i < 3000; i++) begin
      start          = ($urandom_range(0, 29) == 0);
      stop           = ($urandom_range(0, 19) == 0);
      step           = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_target = ($urandom_range(0, 15) == 0) ? 32'($urandom())
                                                     : 32'($urandom_range(0, 270));
      if ($urandom_range(0, 63) == 0) single_step = ~single_step;
      if ($urandom_range(0, 99) == 0) end_pc = 32'($urandom_range(0, 300));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    {start, stop, step, redirect_valid, reset} = '0;
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", longint'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
